// File: rtl/parity_checker_stream.sv
// Registered even/odd parity checker for a valid/ready word stream with a saturating error counter.
// Optional macro DROP_BAD_EN: words failing the check are counted but not forwarded.
module parity_checker_stream #(
    parameter int DATA_W = 8,
    parameter int CNT_W  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_par,
    input  logic              odd_mode,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_err,
    output logic [CNT_W-1:0]  err_cnt,
    input  logic              err_clr
);

    logic              r_valid;
    logic [DATA_W-1:0] r_data;
    logic              r_err;
    logic [CNT_W-1:0]  r_cnt;

    logic w_acc;
    logic w_x;
    logic w_err;
    logic w_load;
    logic w_cnt_inc;
    logic w_cnt_max;

    assign in_ready  = ~r_valid | out_ready;
    assign w_acc     = in_valid & in_ready;
    assign w_x       = ^{in_data, in_par};
    assign w_err     = odd_mode ? ~w_x : w_x;
    assign w_cnt_inc = w_acc & w_err;
    assign w_cnt_max = &r_cnt;

`ifdef DROP_BAD_EN
    // Bad words are consumed from the input but never reach the output register.
    assign w_load = w_acc & ~w_err;
`else
    assign w_load = w_acc;
`endif

    // Output register: loads on accept, releases when drained with nothing new loaded.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid <= 1'b0;
            r_data  <= '0;
            r_err   <= 1'b0;
        end else if (w_load) begin
            r_valid <= 1'b1;
            r_data  <= in_data;
            r_err   <= w_err;
        end else if (r_valid && out_ready) begin
            r_valid <= 1'b0;
        end
    end

    // A clear coinciding with a counted error keeps that error.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (err_clr) begin
            r_cnt <= w_cnt_inc ? CNT_W'(1) : '0;
        end else if (w_cnt_inc && !w_cnt_max) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    assign out_valid = r_valid;
    assign out_data  = r_data;
    assign out_err   = r_err;
    assign err_cnt   = r_cnt;

endmodule

// File: tb/tb_parity_checker_stream.sv
// Scoreboard bench for parity_checker_stream: an 8-bit-counter instance and a 2-bit-counter
// instance share stimulus; a queue holds the expected output-register contents.
module tb_parity_checker_stream;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_valid = 1'b0;
    logic [7:0] in_data = '0;
    logic       in_par = 1'b0;
    logic       odd_mode = 1'b0;
    logic       out_ready = 1'b1;
    logic       err_clr = 1'b0;

    logic       in_ready, out_valid, out_err;
    logic [7:0] out_data, err_cnt;
    logic       in_ready2, out_valid2, out_err2;
    logic [7:0] out_data2;
    logic [1:0] err_cnt2;

    int checks = 0;
    int errors = 0;

    logic [8:0] q[$];
    logic [7:0] exp_cnt = '0;
    logic [1:0] exp_cnt2 = '0;
    logic       exp_rdy;

`ifdef DROP_BAD_EN
    localparam bit DROP = 1'b1;
`else
    localparam bit DROP = 1'b0;
`endif

    always #5 clk = ~clk;

    parity_checker_stream #(.DATA_W(8), .CNT_W(8)) u_dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_par(in_par), .odd_mode(odd_mode),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_err(out_err), .err_cnt(err_cnt), .err_clr(err_clr)
    );

    parity_checker_stream #(.DATA_W(8), .CNT_W(2)) u_sat (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready2),
        .in_data(in_data), .in_par(in_par), .odd_mode(odd_mode),
        .out_valid(out_valid2), .out_ready(out_ready), .out_data(out_data2),
        .out_err(out_err2), .err_cnt(err_cnt2), .err_clr(err_clr)
    );

    // Drive one cycle of stimulus and advance the reference model to its post-edge state.
    task automatic drive(input logic v, input logic [7:0] d, input logic p,
                         input logic odd, input logic ordy, input logic clr);
        logic x, e, acc, ld;
        in_valid = v; in_data = d; in_par = p; odd_mode = odd;
        out_ready = ordy; err_clr = clr;
        exp_rdy = (q.size() == 0) || ordy;
        acc = v && exp_rdy;
        x = ^{d, p};
        e = odd ? ~x : x;
        ld = acc && !(DROP && e);
        if (q.size() != 0 && ordy) void'(q.pop_front());
        if (ld) q.push_back({e, d});
        if (clr) begin
            exp_cnt  = (acc && e) ? 8'd1 : 8'd0;
            exp_cnt2 = (acc && e) ? 2'd1 : 2'd0;
        end else if (acc && e) begin
            if (exp_cnt != 8'hFF) exp_cnt = exp_cnt + 8'd1;
            if (exp_cnt2 != 2'd3) exp_cnt2 = exp_cnt2 + 2'd1;
        end
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        #3;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %0b exp 0", out_valid); end
        checks++; if (out_data !== 8'h00) begin errors++; $display("FAIL reset_data got %0h exp 00", out_data); end
        checks++; if (out_err !== 1'b0) begin errors++; $display("FAIL reset_err got %0b exp 0", out_err); end
        checks++; if (err_cnt !== 8'd0 || err_cnt2 !== 2'd0) begin errors++; $display("FAIL reset_cnt got %0d/%0d exp 0/0", err_cnt, err_cnt2); end
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        tick();
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %0b exp 1", in_ready); end
    endtask

    task automatic test_even();
        drive(1'b1, 8'hA5, 1'b0, 1'b0, 1'b1, 1'b0);
        tick();
        checks++; if (out_valid !== 1'b1 || out_data !== q[0][7:0] || out_err !== q[0][8]) begin errors++; $display("FAIL even_good got v%0b %0h e%0b exp v1 %0h e%0b", out_valid, out_data, out_err, q[0][7:0], q[0][8]); end
        checks++; if (err_cnt !== exp_cnt) begin errors++; $display("FAIL even_good_cnt got %0d exp %0d", err_cnt, exp_cnt); end
        checks++; if (out_valid2 !== 1'b1 || out_data2 !== 8'hA5 || out_err2 !== 1'b0 || in_ready2 !== 1'b1) begin errors++; $display("FAIL even_sat_out got v%0b %0h e%0b r%0b exp v1 a5 e0 r1", out_valid2, out_data2, out_err2, in_ready2); end
        drive(1'b1, 8'hA5, 1'b1, 1'b0, 1'b1, 1'b0);
        tick();
        if (DROP) begin
            checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL even_bad_drop got v%0b exp v0", out_valid); end
        end else begin
            checks++; if (out_valid !== 1'b1 || out_data !== 8'hA5 || out_err !== 1'b1) begin errors++; $display("FAIL even_bad got v%0b %0h e%0b exp v1 a5 e1", out_valid, out_data, out_err); end
        end
        checks++; if (err_cnt !== 8'd1 || err_cnt2 !== 2'd1) begin errors++; $display("FAIL even_bad_cnt got %0d/%0d exp 1/1", err_cnt, err_cnt2); end
        drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0);
        tick();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL even_idle got v%0b exp v0", out_valid); end
    endtask

    task automatic test_odd();
        drive(1'b1, 8'h01, 1'b0, 1'b1, 1'b1, 1'b0);
        tick();
        checks++; if (out_valid !== 1'b1 || out_data !== 8'h01 || out_err !== 1'b0) begin errors++; $display("FAIL odd_good got v%0b %0h e%0b exp v1 01 e0", out_valid, out_data, out_err); end
        drive(1'b1, 8'h03, 1'b0, 1'b1, 1'b1, 1'b0);
        tick();
        if (!DROP) begin
            checks++; if (out_err !== 1'b1 || out_data !== 8'h03) begin errors++; $display("FAIL odd_bad got %0h e%0b exp 03 e1", out_data, out_err); end
        end
        checks++; if (err_cnt !== 8'd2 || err_cnt2 !== 2'd2) begin errors++; $display("FAIL odd_cnt got %0d/%0d exp 2/2", err_cnt, err_cnt2); end
        drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0);
        tick();
    endtask

    task automatic test_backpressure();
        int good;
        drive(1'b1, 8'h11, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        checks++; if (out_valid !== 1'b1 || out_data !== 8'h11) begin errors++; $display("FAIL bp_first got v%0b %0h exp v1 11", out_valid, out_data); end
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 8'h22, 1'b0, 1'b0, 1'b0, 1'b0);
            checks++; if (in_ready !== exp_rdy) begin errors++; $display("FAIL bp_ready got %0b exp %0b", in_ready, exp_rdy); end
            tick();
            checks++; if (out_valid !== 1'b1 || out_data !== q[0][7:0] || out_err !== q[0][8]) begin errors++; $display("FAIL bp_hold got v%0b %0h exp v1 %0h", out_valid, out_data, q[0][7:0]); end
        end
        drive(1'b1, 8'h22, 1'b0, 1'b0, 1'b1, 1'b0);
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_release_ready got %0b exp 1", in_ready); end
        tick();
        checks++; if (out_valid !== 1'b1 || out_data !== 8'h22) begin errors++; $display("FAIL bp_release got v%0b %0h exp v1 22", out_valid, out_data); end
        drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0);
        tick();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_nodup got v%0b exp v0", out_valid); end
        good = 0;
        for (int i = 0; i < 16; i++) begin
            drive(1'b1, 8'(i * 37 + 5), 1'(^8'(i * 37 + 5)), 1'b0, 1'b1, 1'b0);
            tick();
            if (out_valid === 1'b1 && out_data === 8'(i * 37 + 5) && out_err === 1'b0) good++;
        end
        checks++; if (good !== 16) begin errors++; $display("FAIL stream16 got %0d consecutive outputs exp 16", good); end
        checks++; if (err_cnt !== exp_cnt) begin errors++; $display("FAIL stream_cnt got %0d exp %0d", err_cnt, exp_cnt); end
        drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0);
        tick();
    endtask

    task automatic test_saturation();
        drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1);
        tick();
        checks++; if (err_cnt !== 8'd0 || err_cnt2 !== 2'd0) begin errors++; $display("FAIL sat_clr0 got %0d/%0d exp 0/0", err_cnt, err_cnt2); end
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 8'hA5, 1'b1, 1'b0, 1'b1, 1'b0);
            tick();
        end
        checks++; if (err_cnt2 !== 2'd3 || err_cnt2 !== exp_cnt2) begin errors++; $display("FAIL sat_max got %0d exp 3", err_cnt2); end
        checks++; if (err_cnt !== 8'd5) begin errors++; $display("FAIL sat_wide got %0d exp 5", err_cnt); end
        drive(1'b1, 8'hA5, 1'b1, 1'b0, 1'b1, 1'b1);
        tick();
        checks++; if (err_cnt2 !== 2'd1 || err_cnt !== 8'd1) begin errors++; $display("FAIL sat_clr_err got %0d/%0d exp 1/1", err_cnt, err_cnt2); end
        drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1);
        tick();
        checks++; if (err_cnt2 !== 2'd0 || err_cnt !== 8'd0) begin errors++; $display("FAIL sat_clr_only got %0d/%0d exp 0/0", err_cnt, err_cnt2); end
        drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0);
        tick();
    endtask

    task automatic test_async_reset();
        drive(1'b1, 8'hA5, 1'b1, 1'b0, 1'b0, 1'b0);
        tick();
        drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
        checks++; if (err_cnt !== 8'd1) begin errors++; $display("FAIL ar_pre_cnt got %0d exp 1", err_cnt); end
        rst = 1'b1;
        #1;
        q.delete(); exp_cnt = '0; exp_cnt2 = '0;
        checks++; if (out_valid !== 1'b0 || err_cnt !== 8'd0 || err_cnt2 !== 2'd0 || out_data !== 8'h00) begin errors++; $display("FAIL ar_async got v%0b cnt %0d/%0d d %0h exp v0 0/0 00", out_valid, err_cnt, err_cnt2, out_data); end
        #2;
        rst = 1'b0;
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL ar_ready got %0b exp 1", in_ready); end
        drive(1'b1, 8'h5C, 1'b0, 1'b0, 1'b1, 1'b0);
        tick();
        checks++; if (out_valid !== 1'b1 || out_data !== 8'h5C || out_err !== 1'b0) begin errors++; $display("FAIL ar_latency got v%0b %0h exp v1 5c", out_valid, out_data); end
        drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0);
        tick();
    endtask

    task automatic test_drop();
        int n_out, n_bad;
        n_out = 0; n_bad = 0;
        drive(1'b1, 8'h0F, 1'b0, 1'b0, 1'b1, 1'b0);
        tick();
        if (out_valid === 1'b1) begin n_out++; if (out_err !== 1'b0) n_bad++; end
        drive(1'b1, 8'h0F, 1'b1, 1'b0, 1'b1, 1'b0);
        tick();
        checks++; if (out_valid !== (q.size() != 0)) begin errors++; $display("FAIL drop_mid got v%0b exp v%0b", out_valid, q.size() != 0); end
        if (out_valid === 1'b1) begin n_out++; if (out_err !== 1'b0) n_bad++; end
        drive(1'b1, 8'h33, 1'b0, 1'b0, 1'b1, 1'b0);
        tick();
        if (out_valid === 1'b1) begin n_out++; if (out_err !== 1'b0) n_bad++; end
        checks++; if (n_out !== (DROP ? 2 : 3) || n_bad !== (DROP ? 0 : 1)) begin errors++; $display("FAIL drop_count got %0d outputs %0d flagged exp %0d/%0d", n_out, n_bad, DROP ? 2 : 3, DROP ? 0 : 1); end
        checks++; if (err_cnt !== exp_cnt || err_cnt !== 8'd1) begin errors++; $display("FAIL drop_cnt got %0d exp 1", err_cnt); end
        drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0);
        tick();
    endtask

    initial begin
        test_reset();
        test_even();
        test_odd();
        test_backpressure();
        test_saturation();
        test_async_reset();
        test_drop();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
